// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock,
// valid/ready handshakes on operand input and result output.
module seq_restoring_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CW = $clog2(DIVIDEND_W + 1);
    localparam logic [DIVISOR_W:0] ONE = {{DIVISOR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DIVIDEND_W-1:0]   q_q, q_d;
    logic [DIVISOR_W-1:0]    d_q, d_d;
    logic [DIVISOR_W:0]      r_q, r_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    z_q, z_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [DIVIDEND_W-1:0]   quot_q, quot_d;
    logic [DIVISOR_W-1:0]    rem_q, rem_d;
    logic                    dbz_q, dbz_d;

    logic [DIVISOR_W:0]      r_shift;
    logic [DIVISOR_W:0]      trial;

    // Guard bit of R is always 0 between iterations, so it can be dropped on the shift.
    assign r_shift = {r_q[DIVISOR_W-1:0], q_q[DIVIDEND_W-1]};
    assign trial   = r_shift + ~{1'b0, d_q} + ONE;

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        d_d         = d_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        z_d         = z_q;
        out_valid_d = out_valid_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    q_d   = dividend;
                    d_d   = divisor;
                    r_d   = '0;
                    cnt_d = CW'(DIVIDEND_W);
                    z_d   = 1'b0;
                    if (divisor == '0) begin
                        q_d     = '1;
                        r_d     = {1'b0, dividend[DIVISOR_W-1:0]};
                        z_d     = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = trial[DIVISOR_W] ? r_shift : trial;
                q_d   = {q_q[DIVIDEND_W-2:0], ~trial[DIVISOR_W]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = DONE;
            end
            DONE: begin
                // First DONE cycle loads the result registers; later cycles wait for the consumer.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    quot_d      = q_q;
                    rem_d       = r_q[DIVISOR_W-1:0];
                    dbz_d       = z_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            z_q         <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            d_q         <= d_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            z_q         <= z_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
